// File: rtl/voice_allocator_pkg.sv
// Shared types and defaults for the voice allocator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package voice_allocator_pkg;

    localparam int NUM_VOICES_DEF = 3;
    localparam int NOTE_W_DEF     = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/dffr.sv
// Plain register with synchronous active-high reset to RST_VAL.
// Latency: 1 cycle.
// Backpressure: none; loads every cycle.
module dffr #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every edge unless reset.
    always_ff @(posedge clk) begin
        if (reset) q <= RST_VAL;
        else       q <= d;
    end

endmodule

// File: rtl/dffre.sv
// Register with load enable and synchronous active-high reset to RST_VAL.
// Latency: 1 cycle.
// Backpressure: holds its value while en is low.
module dffre #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d only on enabled edges.
    always_ff @(posedge clk) begin
        if (reset)   q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/voice_allocator_lru_tracker.sv
// LRU rank per voice (0 = oldest); a grant moves the voice to the newest rank.
// Latency: rank update visible the cycle after grant_vld; oldest_idx is combinational from ranks.
// Backpressure: none; every grant is accepted.
module lru_tracker
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          grant_vld,
    input  logic [$clog2(NUM_VOICES)-1:0] grant_idx,
    output logic [$clog2(NUM_VOICES)-1:0] oldest_idx
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int RW = NUM_VOICES * IW;

    function automatic logic [RW-1:0] init_ranks();
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_VOICES; i++) r[i*IW +: IW] = IW'(i);
        return r;
    endfunction

    localparam logic [RW-1:0] RANK_RST = init_ranks();

    logic [RW-1:0] rank_q, rank_d;
    logic [IW-1:0] old_rank, cur_rank;

    dffr #(.W(RW), .RST_VAL(RANK_RST)) u_rank (
        .clk   (clk),
        .reset (reset),
        .d     (rank_d),
        .q     (rank_q)
    );

    // Granted voice becomes newest; voices that were newer than it age by one.
    always_comb begin
        rank_d   = rank_q;
        old_rank = rank_q[grant_idx*IW +: IW];
        cur_rank = '0;
        if (grant_vld) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                cur_rank = rank_q[i*IW +: IW];
                if (IW'(i) == grant_idx)
                    rank_d[i*IW +: IW] = IW'(NUM_VOICES - 1);
                else if (cur_rank > old_rank)
                    rank_d[i*IW +: IW] = cur_rank - IW'(1);
            end
        end
    end

    // The voice holding rank 0 is the steal candidate.
    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (rank_q[i*IW +: IW] == '0) oldest_idx = IW'(i);
    end

endmodule

// File: rtl/voice_allocator.sv
// Allocates incoming notes to the lowest free note_player voice; VOICE_STEAL_EN steals the oldest voice when all are busy.
// Latency: load_new_note in cycle N gives voice_load in cycle N+2.
// Backpressure: one-entry skid absorbs a request during ALLOC/LOAD; further requests are dropped with note_dropped.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int NOTE_W     = NOTE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_new_note,
    input  logic [NOTE_W-1:0]     note_to_load,
    input  logic [NOTE_W-1:0]     duration_to_load,
    input  logic [NUM_VOICES-1:0] voice_idle,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     note_out,
    output logic [NOTE_W-1:0]     duration_out,
    output logic [NUM_VOICES-1:0] busy_mask,
    output logic                  note_dropped,
    output logic                  voice_stolen
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [NUM_VOICES-1:0] ONE_HOT0 = NUM_VOICES'(1);
`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    state_t                state;
    logic [NUM_VOICES-1:0] idle_q, idle_rise, busy_next;
    logic [IW-1:0]         sel_q, free_idx, oldest_idx, tgt_idx;
    logic                  all_busy, take_req, skid_vld, skid_vld_next;
    logic                  skid_load, skid_drop, alloc_fail, pend_clr, pend_en;
    logic [NOTE_W-1:0]     pend_note, pend_dur, skid_note, skid_dur;
    logic [NOTE_W-1:0]     pend_note_d, pend_dur_d;

    dffr #(.W(NUM_VOICES)) u_idle_q (.clk(clk), .reset(reset), .d(voice_idle), .q(idle_q));
    dffr #(.W(NUM_VOICES)) u_busy   (.clk(clk), .reset(reset), .d(busy_next), .q(busy_mask));
    dffr #(.W(1))          u_skid_v (.clk(clk), .reset(reset), .d(skid_vld_next), .q(skid_vld));
    dffre #(.W(NOTE_W)) u_skid_n (.clk(clk), .reset(reset), .en(skid_load), .d(note_to_load),     .q(skid_note));
    dffre #(.W(NOTE_W)) u_skid_d (.clk(clk), .reset(reset), .en(skid_load), .d(duration_to_load), .q(skid_dur));
    dffre #(.W(NOTE_W)) u_pend_n (.clk(clk), .reset(reset), .en(pend_en),   .d(pend_note_d),      .q(pend_note));
    dffre #(.W(NOTE_W)) u_pend_d (.clk(clk), .reset(reset), .en(pend_en),   .d(pend_dur_d),       .q(pend_dur));

    lru_tracker #(.NUM_VOICES(NUM_VOICES)) u_lru (
        .clk        (clk),
        .reset      (reset),
        .grant_vld  (state == S_LOAD),
        .grant_idx  (sel_q),
        .oldest_idx (oldest_idx)
    );

    // Busy tracking: only an idle rising edge frees a voice, and the load pulse re-arms it (load wins).
    always_comb begin
        idle_rise = voice_idle & ~idle_q;
        busy_next = (busy_mask & ~idle_rise) | voice_load;
        all_busy  = &busy_mask;
    end

    // Lowest-index free voice, falling back to the oldest when none is free.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--)
            if (!busy_mask[i]) free_idx = IW'(i);
        tgt_idx = all_busy ? oldest_idx : free_idx;
    end

    // Request intake: skid is drained into pending first, new requests during ALLOC/LOAD park in the skid.
    always_comb begin
        take_req      = (state == S_IDLE) && (skid_vld || load_new_note);
        skid_load     = load_new_note && ((state == S_IDLE) ? skid_vld : !skid_vld);
        skid_drop     = load_new_note && (state != S_IDLE) && skid_vld;
        skid_vld_next = skid_load || (skid_vld && (state != S_IDLE));
        // The ALLOC cycle sees busy_next as its busy_mask, so the drop can be flagged on entry.
        alloc_fail    = take_req && (&busy_next) && !STEAL_EN;
        pend_clr      = (state == S_ALLOC) && all_busy && !STEAL_EN;
        pend_en       = take_req || pend_clr;
        pend_note_d   = pend_clr ? '0 : (skid_vld ? skid_note : note_to_load);
        pend_dur_d    = pend_clr ? '0 : (skid_vld ? skid_dur  : duration_to_load);
    end

    // Allocation FSM with registered load, data and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            voice_load   <= '0;
            note_out     <= '0;
            duration_out <= '0;
            note_dropped <= 1'b0;
            voice_stolen <= 1'b0;
        end else begin
            voice_load   <= '0;
            voice_stolen <= 1'b0;
            note_dropped <= skid_drop || alloc_fail;
            case (state)
                S_IDLE: begin
                    if (take_req) state <= S_ALLOC;
                end
                S_ALLOC: begin
                    if (!all_busy || STEAL_EN) begin
                        sel_q        <= tgt_idx;
                        voice_load   <= ONE_HOT0 << tgt_idx;
                        note_out     <= pend_note;
                        duration_out <= pend_dur;
                        voice_stolen <= all_busy && STEAL_EN;
                        state        <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
